// File: rtl/register_bank.sv
// General-purpose register bank: NREG load-enabled registers, two read ports,
// and a PC (top register) that can increment in place; sticky multi-write flag.
module register_bank #(
   parameter int N    = 16,
   parameter int NREG = 8,
   parameter int AW   = 3
) (
   input  logic            Clock,
   input  logic            Resetn,
   input  logic [N-1:0]    RegEntrada,
   input  logic [NREG-1:0] RIn,
   input  logic            IncrPC,
   input  logic [AW-1:0]   RdAddrA,
   input  logic [AW-1:0]   RdAddrB,
   output logic [N-1:0]    RdDataA,
   output logic [N-1:0]    RdDataB,
   output logic [N-1:0]    PCOut,
   output logic            WrErr
);

   logic [N-1:0] r_regs [NREG];
   logic         r_wrErr;
   logic [N-1:0] w_readTable [2**AW];

   // A load on the PC takes priority over the increment.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         for (int i = 0; i < NREG; i++) begin
            r_regs[i] <= '0;
         end
         r_wrErr <= 1'b0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (RIn[i]) begin
               r_regs[i] <= RegEntrada;
            end else if ((i == NREG - 1) && IncrPC) begin
               r_regs[i] <= r_regs[i] + N'(1);
            end
         end
         if ($countones(RIn) > 1) begin
            r_wrErr <= 1'b1;
         end
      end
   end

   // Addresses beyond the last register read back as zero.
   for (genvar g = 0; g < 2**AW; g++) begin : g_read
      if (g < NREG) begin : g_real
         assign w_readTable[g] = r_regs[g];
      end else begin : g_empty
         assign w_readTable[g] = '0;
      end
   end

   assign RdDataA = w_readTable[RdAddrA];
   assign RdDataB = w_readTable[RdAddrB];
   assign PCOut   = r_regs[NREG-1];
   assign WrErr   = r_wrErr;

endmodule

// File: tb/tb_register_bank.sv
// Randomised bench for register_bank: an array-based reference model checked
// every cycle, plus hand-computed expectations for the key scenarios.
module tb_register_bank;

   logic        Clock;
   logic        Resetn;
   logic [15:0] RegEntrada;
   logic [7:0]  RIn;
   logic        IncrPC;
   logic [2:0]  RdAddrA;
   logic [2:0]  RdAddrB;
   logic [15:0] RdDataA8, RdDataB8, PCOut8;
   logic        WrErr8;
   logic [15:0] RdDataA6, RdDataB6, PCOut6;
   logic        WrErr6;

   logic [15:0] m8 [8];
   logic [15:0] m6 [8];
   logic        e8, e6;
   logic        checkEn;
   int          vectors;
   int          miscompares;

   register_bank #(.N(16), .NREG(8), .AW(3)) dut8 (
      .Clock(Clock), .Resetn(Resetn), .RegEntrada(RegEntrada), .RIn(RIn),
      .IncrPC(IncrPC), .RdAddrA(RdAddrA), .RdAddrB(RdAddrB),
      .RdDataA(RdDataA8), .RdDataB(RdDataB8), .PCOut(PCOut8), .WrErr(WrErr8)
   );

   register_bank #(.N(16), .NREG(6), .AW(3)) dut6 (
      .Clock(Clock), .Resetn(Resetn), .RegEntrada(RegEntrada), .RIn(RIn[5:0]),
      .IncrPC(IncrPC), .RdAddrA(RdAddrA), .RdAddrB(RdAddrB),
      .RdDataA(RdDataA6), .RdDataB(RdDataB6), .PCOut(PCOut6), .WrErr(WrErr6)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Reference model: plain arrays updated from the rules of each edge.
   always @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         for (int i = 0; i < 8; i++) begin
            m8[i] = 16'h0;
            m6[i] = 16'h0;
         end
         e8 = 1'b0;
         e6 = 1'b0;
      end else begin
         int ones8, ones6;
         ones8 = 0;
         ones6 = 0;
         for (int i = 0; i < 8; i++) begin
            if (RIn[i]) ones8++;
            if (i < 6 && RIn[i]) ones6++;
         end
         if (ones8 > 1) e8 = 1'b1;
         if (ones6 > 1) e6 = 1'b1;
         for (int i = 0; i < 8; i++) begin
            if (RIn[i]) m8[i] = RegEntrada;
            else if (i == 7 && IncrPC) m8[i] = m8[i] + 16'd1;
         end
         for (int i = 0; i < 6; i++) begin
            if (RIn[i]) m6[i] = RegEntrada;
            else if (i == 5 && IncrPC) m6[i] = m6[i] + 16'd1;
         end
      end
   end

   function automatic logic [15:0] read8(input logic [2:0] a);
      return m8[a];
   endfunction

   function automatic logic [15:0] read6(input logic [2:0] a);
      return (a < 3'd6) ? m6[a] : 16'h0;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic checkOutput();
      check("rdA8", RdDataA8, read8(RdAddrA));
      check("rdB8", RdDataB8, read8(RdAddrB));
      check("pc8", PCOut8, m8[7]);
      check("err8", {15'h0, WrErr8}, {15'h0, e8});
      check("rdA6", RdDataA6, read6(RdAddrA));
      check("rdB6", RdDataB6, read6(RdAddrB));
      check("pc6", PCOut6, m6[5]);
      check("err6", {15'h0, WrErr6}, {15'h0, e6});
   endtask

   // Compare process: mid-cycle, after new inputs settle and before the edge.
   always @(negedge Clock) begin
      #2;
      if (checkEn) checkOutput();
   end

   task automatic applyStimulus(input logic [7:0] rin, input logic [15:0] data,
                                input logic incr, input logic [2:0] a, input logic [2:0] b);
      @(negedge Clock);
      RIn        = rin;
      RegEntrada = data;
      IncrPC     = incr;
      RdAddrA    = a;
      RdAddrB    = b;
   endtask

   task automatic randomStep();
      logic [7:0] rin;
      int sel;
      sel = $urandom_range(0, 39);
      if (sel == 0) rin = 8'($urandom);
      else if (sel < 12) rin = 8'h0;
      else rin = 8'h1 << $urandom_range(0, 7);
      applyStimulus(rin, 16'($urandom), 1'($urandom), 3'($urandom), 3'($urandom));
   endtask

   task automatic midReset();
      @(negedge Clock);
      #3;
      Resetn = 1'b0;
      #1;
      check("asyncRstPc8", PCOut8, 16'h0);
      check("asyncRstRdA8", RdDataA8, 16'h0);
      check("asyncRstErr8", {15'h0, WrErr8}, 16'h0);
      repeat (2) randomStep();
      applyStimulus(8'h0, 16'h0, 1'b0, 3'($urandom), 3'($urandom));
      Resetn = 1'b1;
   endtask

   initial begin
      logic [15:0] pcSeq [4];
      pcSeq[0] = 16'hFFFE; pcSeq[1] = 16'hFFFF; pcSeq[2] = 16'h0000; pcSeq[3] = 16'h0001;
      vectors = 0;
      miscompares = 0;
      checkEn = 1'b0;
      Resetn = 1'b1;
      RIn = 8'h0; RegEntrada = 16'h0; IncrPC = 1'b0; RdAddrA = 3'd0; RdAddrB = 3'd0;
      #1 Resetn = 1'b0;
      repeat (2) @(negedge Clock);
      check("rstPc", PCOut8, 16'h0);
      check("rstErr", {15'h0, WrErr8}, 16'h0);
      checkEn = 1'b1;
      Resetn = 1'b1;

      applyStimulus(8'b0000_0100, 16'h1234, 1'b0, 3'd2, 3'd0);
      #3 check("preEdgeOld", RdDataA8, 16'h0000);
      applyStimulus(8'h0, 16'h0, 1'b0, 3'd2, 3'd1);
      #3 check("writeR2", RdDataA8, 16'h1234);
      check("otherHeld", RdDataB8, 16'h0000);

      applyStimulus(8'h80, 16'hFFFE, 1'b0, 3'd7, 3'd7);
      for (int k = 0; k < 4; k++) begin
         applyStimulus(8'h0, 16'h0, (k < 3), 3'd7, 3'd0);
         #3 check("pcWrap", PCOut8, pcSeq[k]);
      end

      applyStimulus(8'h80, 16'h0010, 1'b0, 3'd7, 3'd0);
      applyStimulus(8'h80, 16'h00A0, 1'b1, 3'd7, 3'd0);
      applyStimulus(8'h0, 16'h0, 1'b0, 3'd7, 3'd0);
      #3 check("collision", PCOut8, 16'h00A0);

      applyStimulus(8'b0001_0010, 16'hBEEF, 1'b0, 3'd1, 3'd4);
      applyStimulus(8'h0, 16'h0, 1'b1, 3'd1, 3'd4);
      #3 check("multiR1", RdDataA8, 16'hBEEF);
      check("multiR4", RdDataB8, 16'hBEEF);
      check("multiErr", {15'h0, WrErr8}, 16'h1);
      repeat (10) applyStimulus(8'h0, 16'h0, 1'b0, 3'd0, 3'd0);
      #3 check("errSticky", {15'h0, WrErr8}, 16'h1);

      applyStimulus(8'h08, 16'h5A5A, 1'b0, 3'd3, 3'd3);
      applyStimulus(8'h0, 16'h0, 1'b0, 3'd3, 3'd3);
      #3 check("sameAddrA", RdDataA8, 16'h5A5A);
      check("sameAddrB", RdDataB8, 16'h5A5A);

      applyStimulus(8'h3F, 16'h7777, 1'b0, 3'd6, 3'd7);
      applyStimulus(8'h0, 16'h0, 1'b0, 3'd6, 3'd7);
      #3 check("n6Addr6", RdDataA6, 16'h0000);
      check("n6Addr7", RdDataB6, 16'h0000);

      midReset();
      #3 check("errCleared", {15'h0, WrErr8}, 16'h0);

      for (int r = 0; r < 3; r++) begin
         repeat (150) randomStep();
         midReset();
      end
      repeat (50) randomStep();

      @(negedge Clock);
      #3;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
